// File: rtl/display_pkg.sv
// display_pkg
//   Shared constants for the six-digit multiplexed time display:
//   active-low seven-segment patterns ({g,f,e,d,c,b,a}, 0 = lit),
//   the blink field-select encoding, the digit count, and a helper
//   that maps a scan index to the time field that owns it.
package display_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;   // g only
    localparam logic [6:0] SEG_OFF  = 7'h7F;   // all segments dark

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_HOUR = 2'd1,
        SEL_MIN  = 2'd2,
        SEL_SEC  = 2'd3
    } field_sel_e;

    // Digits 0-1 are hours, 2-3 minutes, 4-5 seconds.
    function automatic field_sel_e digit_field(input logic [2:0] idx);
        field_sel_e f;
        case (idx)
            3'd0, 3'd1: f = SEL_HOUR;
            3'd2, 3'd3: f = SEL_MIN;
            3'd4, 3'd5: f = SEL_SEC;
            default:    f = SEL_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD to active-low seven-segment decoder.
//   Values above 9 are not valid BCD and render as a dash.
// Ports:
//   bcd  in  [3:0]  digit value
//   seg  out [6:0]  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scan.sv
// time_display_scan
//   Scans six BCD time digits onto a common-anode seven-segment display,
//   one digit per SCAN_DIV cycles. All six digits are captured together on
//   entry to digit 0 so a frame never mixes old and new values.
//   Optional field blinking is built when DISP_BLINK_EN is defined; without
//   it set_sel is ignored and every digit is driven every frame.
// Parameters:
//   SCAN_DIV   cycles per digit (>= 2)
//   BLINK_DIV  frames per blink half-period (>= 1)
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   Hh,Hl,mh,ml,sh,sl   BCD time digits
//   set_sel             field to blink (0 none, 1 h, 2 m, 3 s)
//   seg                 segments {g,f,e,d,c,b,a}, active-low, registered
//   an                  digit enables, active-low, an[0] = leftmost
//   dp                  colon/decimal point, active-low
module time_display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Hh,
    input  logic [3:0] Hl,
    input  logic [3:0] mh,
    input  logic [3:0] ml,
    input  logic [3:0] sh,
    input  logic [3:0] sl,
    input  logic [1:0] set_sel,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   snap_q, snap_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    an_q, an_d;
    logic          dp_q, dp_d;

    logic          cnt_last;
    logic          frame_end;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic          blank;

    always_comb begin
        cnt_last  = (cnt_q == CNT_LAST);
        frame_end = cnt_last && (idx_q == IDX_LAST);

        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_last)
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;

        // Capture on the same edge that moves idx back to 0.
        snap_d = frame_end ? {Hh, Hl, mh, ml, sh, sl} : snap_q;
    end

    always_comb begin
        cur_digit = 4'd0;
        case (idx_q)
            3'd0:    cur_digit = snap_q[23:20];
            3'd1:    cur_digit = snap_q[19:16];
            3'd2:    cur_digit = snap_q[15:12];
            3'd3:    cur_digit = snap_q[11:8];
            3'd4:    cur_digit = snap_q[7:4];
            3'd5:    cur_digit = snap_q[3:0];
            default: cur_digit = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef DISP_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          blink_ph_q, blink_ph_d;

    // Phase flips on frame boundaries only, so blanking is frame-aligned.
    always_comb begin
        frame_d    = frame_q;
        blink_ph_d = blink_ph_q;
        if (frame_end) begin
            if (frame_q == FRAME_LAST) begin
                frame_d    = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        // set_sel is live (not snapshotted) so edits respond next cycle.
        blank = blink_ph_q && (field_sel_e'(set_sel) != SEL_NONE) &&
                (digit_field(idx_q) == field_sel_e'(set_sel));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q    <= '0;
            blink_ph_q <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            blink_ph_q <= blink_ph_d;
        end
    end
`else
    logic unused_set_sel;
    assign unused_set_sel = ^set_sel;
    assign blank = 1'b0;
`endif

    // Output stage: registered, so outputs trail idx by one cycle.
    always_comb begin
        seg_d = dec_seg;
        an_d  = ~(6'd1 << idx_q);
        dp_d  = ~((idx_q == 3'd1) || (idx_q == 3'd3));
        if (blank) begin
            seg_d = SEG_OFF;
            an_d  = 6'h3F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            snap_q <= '0;
            seg_q  <= SEG_OFF;
            an_q   <= 6'h3F;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan
//   Directed bench for time_display_scan with SCAN_DIV=4, BLINK_DIV=2.
//   Outputs are sampled on the falling clock edge.
module tb_time_display_scan;

    localparam int SD = 4;
    localparam int BD = 2;

`ifdef DISP_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Hh, Hl, mh, ml, sh, sl;
    logic [1:0] set_sel;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    time_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk     (clk),
        .rst     (rst),
        .Hh      (Hh),
        .Hl      (Hl),
        .mh      (mh),
        .ml      (ml),
        .sh      (sh),
        .sl      (sl),
        .set_sel (set_sel),
        .seg     (seg),
        .an      (an),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Hand-written active-low patterns, indexed by digit value.
    function automatic logic [6:0] pat(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    // Check one digit slot for n cycles; blank expects the dark state.
    task automatic check_digit(input int d, input logic [6:0] s, input bit blank, input int n);
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        exp_an  = blank ? 6'h3F : ~(6'd1 << d);
        exp_seg = blank ? 7'h7F : s;
        exp_dp  = blank ? 1'b1 : ((d == 1 || d == 3) ? 1'b0 : 1'b1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("an_d%0d", d),  32'(an),  32'(exp_an));
            check($sformatf("seg_d%0d", d), 32'(seg), 32'(exp_seg));
            check($sformatf("dp_d%0d", d),  32'(dp),  32'(exp_dp));
        end
    endtask

    task automatic check_frame(input int f, input logic [6:0] p0, input logic [6:0] p1,
                               input logic [6:0] p2, input logic [6:0] p3,
                               input logic [6:0] p4, input logic [6:0] p5, input bit min_sel);
        bit bl;
        bl = BLINK_ON && min_sel && (((f / BD) % 2) == 1);
        check_digit(0, p0, 1'b0, SD);
        check_digit(1, p1, 1'b0, SD);
        check_digit(2, p2, bl, SD);
        check_digit(3, p3, bl, SD);
        check_digit(4, p4, 1'b0, SD);
        check_digit(5, p5, 1'b0, SD);
    endtask

    initial begin
        rst = 1'b1;
        Hh = 4'd1; Hl = 4'd2; mh = 4'd3; ml = 4'd4; sh = 4'd5; sl = 4'd6;
        set_sel = 2'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an",  32'(an),  32'h3F);
        check("rst_dp",  32'(dp),  32'h1);
        rst = 1'b0;

        // Frame 0: snapshot still holds reset zeros.
        check_frame(0, pat(0), pat(0), pat(0), pat(0), pat(0), pat(0), 1'b0);

        // Frame 1: 12:34:56; inputs changed mid-frame must not show yet.
        check_digit(0, pat(1), 1'b0, SD);
        check_digit(1, pat(2), 1'b0, SD);
        sl = 4'd7;
        Hh = 4'hB;
        check_digit(2, pat(3), 1'b0, SD);
        check_digit(3, pat(4), 1'b0, SD);
        check_digit(4, pat(5), 1'b0, SD);
        check_digit(5, pat(6), 1'b0, SD);

        // Frame 2: new snapshot, dash on digit 0 and 7 on digit 5.
        check_frame(2, 7'h3F, pat(2), pat(3), pat(4), pat(5), pat(7), 1'b0);

        // Frames 3..6 with minutes selected: blank in odd half-periods.
        set_sel = 2'd2;
        for (int f = 3; f <= 6; f++)
            check_frame(f, 7'h3F, pat(2), pat(3), pat(4), pat(5), pat(7), 1'b1);
        set_sel = 2'd0;

        // Frame 7: reset at idx 3, cnt 2.
        check_digit(0, 7'h3F, 1'b0, SD);
        check_digit(1, pat(2), 1'b0, SD);
        check_digit(2, pat(3), 1'b0, SD);
        check_digit(3, pat(4), 1'b0, 2);
        rst = 1'b1;
        #1;
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_an",  32'(an),  32'h3F);
        check("midrst_dp",  32'(dp),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        check_digit(0, pat(0), 1'b0, SD);
        check_digit(1, pat(0), 1'b0, SD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
